uart_rx_rtl: RTL and testbench
==============================

Name: uart_rx_rtl

Overview:
UART receiver, the downstream counterpart of the UART transmitter: 8N1 serial in, parallel byte out. It synchronises `rxd`, finds the start bit, and samples each bit at mid-bit using a baud counter. Each received byte goes into a one-entry holding register with a valid/ready handshake for the consuming logic. Framing errors and overruns are flagged; the line is assumed to idle high.

Parameters:
CLK_FREQUENCY, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE (integer division, 434 at defaults)

Ports:
clk  input  1  system clock, all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
rxd  input  1  serial input, asynchronous to clk, idle high
rx_data  output  8  received byte, valid while rx_valid = 1
rx_valid  output  1  holding register contains an unconsumed byte
rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_overrun  output  1  one-cycle pulse: byte completed while holding register full and not being consumed

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low.
- Reset values: rx_data = 8'h00, rx_valid = 0, rx_frame_err = 0, rx_overrun = 0; FSM = IDLE; synchroniser flops = 1; baud counter and bit index = 0.
- Deassertion of rst_n is synchronised in the usual way. No output glitches on deassertion.
- Synchroniser: 2 flops on `rxd`. All FSM decisions use the synchronised value `rxd_s`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on `rxd_s` = 0, load counter 0 and go to START.
  - START: count to CLKS_PER_BIT/2 - 1 (mid start bit), then re-sample.
    - Low: go to DATA with counter 0 and bit index 0.
    - High: false start, go to IDLE with no flags.
  - DATA: every CLKS_PER_BIT cycles, shift `rxd_s` into the shift register, LSB first. After bit index 7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit.
    - High: byte complete.
    - Low: pulse rx_frame_err, discard the byte, go to IDLE. A low line is re-detected as a new start only after `rxd_s` returns high (IDLE requires a 1→0 transition).
- Byte complete:
  - On the cycle after the stop sample, rx_data takes the shift register and rx_valid = 1. FSM returns to IDLE at the stop-bit midpoint, leaving half a bit of margin for the next start.
  - Latency: rx_valid rises 2 (sync) + 1 cycles after the stop bit's mid-point on pad `rxd`.
- Handshake:
  - rx_valid && rx_ready clears rx_valid next cycle.
  - rx_data holds its value while rx_valid = 1.
  - rx_ready is ignored while rx_valid = 0.
- Byte completes while rx_valid = 1:
  - If rx_ready = 1 the same cycle, load the new byte, keep rx_valid = 1, no overrun.
  - Otherwise keep the old byte, drop the new one, and pulse rx_overrun for 1 cycle.
- Flags: rx_frame_err and rx_overrun are single-cycle pulses, never both in the same cycle.
- Counter width: $clog2(CLKS_PER_BIT). CLKS_PER_BIT < 4 is illegal; an elaboration-time check fails it.
- Reset mid-frame: everything returns to reset values immediately. The partial byte is lost and no flags pulse.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: frame is 8E1. A PARITY state sits between DATA and STOP and samples one extra bit at CLKS_PER_BIT spacing.
- Parity check: even parity over data + parity bit must be 0. On mismatch, pulse the added output port rx_parity_err (1 bit, reset 0) for one cycle, in the same cycle the frame would otherwise complete, and discard the byte.
- A frame error takes priority over a parity error.
- Undefined: 8N1 only; no PARITY state and no rx_parity_err port.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef (IDLE, START, DATA, STOP, PARITY);
  - the function computing CLKS_PER_BIT from the frequency and baud rate;
  - DATA_BITS = 8.
- The transmitter shares this package.
- One sub-module, uart_sync2: a generic 2-flop synchroniser with a reset value parameter (set to 1 here).

Test Plan:
- 8'h6D sent at 115200 baud, 50 MHz, rx_ready = 1 → one rx_valid pulse with rx_data = 8'h6D; no flags.
- Back-to-back 8'h6D then 8'hD5 with rx_ready held 0 → rx_data stays 8'h6D; rx_overrun pulses once at the end of the second byte; after rx_ready = 1, rx_valid drops.
- Stop bit forced low on 8'hA5 → rx_frame_err one-cycle pulse; rx_valid stays 0; the next good byte 8'h3C is received correctly.
- Glitch on `rxd` low for 100 clks (< half bit) → no state change beyond START→IDLE; no outputs change.
- rst_n asserted during DATA bit 4 → all outputs at reset values immediately; the following full byte 8'hFF is received correctly.
- With UART_RX_PARITY_EN: 8'h6D with a wrong parity bit → rx_parity_err pulse and no rx_valid; with correct parity → rx_data = 8'h6D.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, bit-period helper and data width.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } uart_state_t;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_frequency,
                                                    input int unsigned baud_rate);
    return clk_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser with a configurable reset value.
// Serves both as the rxd input synchroniser and as the reset-deassertion synchroniser.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_rtl.sv
// UART receiver: 8N1 by default, 8E1 with rx_parity_err when UART_RX_PARITY_EN is defined.
// Mid-bit sampling from a baud counter; one-entry holding register with valid/ready handshake.
module uart_rx_rtl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQUENCY, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t HALF_LAST = cnt_t'(HALF_BIT - 1);
  localparam idx_t IDX_LAST  = idx_t'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx_rtl: CLKS_PER_BIT must be at least 4");
  end

  logic                 rst_int_n;
  logic                 rxd_s;
  logic                 rxd_prev;
  uart_state_t          state;
  uart_state_t          state_next;
  cnt_t                 cnt;
  idx_t                 bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 half_tick;
  logic                 bit_tick;
  logic                 cnt_clr;
  logic                 shift_en;
  logic                 stop_tick;
  logic                 frame_bad;
  logic                 par_bad;
  logic                 byte_done;

  // Reset asserts asynchronously but releases two clocks later, on a clock edge.
  uart_sync2 #(.RESET_VALUE(1'b0)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_int_n)
  );

  uart_sync2 #(.RESET_VALUE(1'b1)) u_rxd_sync (
    .clk   (clk),
    .rst_n (rst_int_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign half_tick = (cnt == HALF_LAST);
  assign bit_tick  = (cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= IDLE;
      rxd_prev <= 1'b1;
    end else begin
      state    <= state_next;
      rxd_prev <= rxd_s;
    end
  end

  // IDLE waits for a 1->0 edge so a line held low after a framing error is not re-taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (rxd_prev && !rxd_s) state_next = START;
      START: if (half_tick) state_next = rxd_s ? IDLE : DATA;
      DATA:  if (bit_tick && (bit_idx == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
             end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_tick) state_next = STOP;
`endif
      STOP:  if (bit_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = (state == IDLE) || (state_next != state) || bit_tick;
    shift_en  = (state == DATA) && bit_tick;
    stop_tick = (state == STOP) && bit_tick;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (state != DATA) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (shift_en) begin
        shift <= {rxd_s, shift[DATA_BITS-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      par_bit <= 1'b0;
    end else if ((state == PARITY) && bit_tick) begin
      par_bit <= rxd_s;
    end
  end

  assign par_bad = stop_tick && rxd_s && (^{shift, par_bit});
`else
  assign par_bad = 1'b0;
`endif

  assign frame_bad = stop_tick && !rxd_s;
  assign byte_done = stop_tick && rxd_s && !par_bad;

  // A completing byte may replace the held one only if it is being consumed this same cycle.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= frame_bad;
      rx_overrun   <= byte_done && rx_valid && !rx_ready;
      if (byte_done && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rx_parity_err <= 1'b0;
    end else begin
      rx_parity_err <= par_bad;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_rtl.sv
// Self-checking bench for uart_rx_rtl at 50 MHz / 115200 baud (434 clocks per bit).
// Received bytes are scoreboarded against bytes expected from the driven frames.
module tb_uart_rx_rtl;

  localparam int unsigned CLK_FREQUENCY = 50_000_000;
  localparam int unsigned BAUD_RATE     = 115200;
  localparam int unsigned CPB           = CLK_FREQUENCY / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
  logic       par_flip = 1'b0;
  int         n_perr = 0;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int   n_vrise = 0;
  int   n_ferr  = 0;
  int   n_ovr   = 0;
  int   n_long  = 0;
  int   n_both  = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;
  logic prev_ovr   = 1'b0;

  uart_rx_rtl #(
    .CLK_FREQUENCY (CLK_FREQUENCY),
    .BAUD_RATE     (BAUD_RATE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxd           (rxd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .rx_parity_err (rx_parity_err)
`endif
  );

  always #10 clk = ~clk;

  // Observation only: record handshaken bytes and flag pulses.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid && !prev_valid) n_vrise++;
    if (rx_frame_err) n_ferr++;
    if (rx_overrun) n_ovr++;
    if ((rx_frame_err && prev_ferr) || (rx_overrun && prev_ovr)) n_long++;
    if (rx_frame_err && rx_overrun) n_both++;
`ifdef UART_RX_PARITY_EN
    if (rx_parity_err) n_perr++;
`endif
    prev_valid = rx_valid;
    prev_ferr  = rx_frame_err;
    prev_ovr   = rx_overrun;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick();
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ par_flip;
    repeat (CPB) tick();
`endif
    rxd = stop_val;
    repeat (CPB) tick();
    rxd = 1'b1;
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got_q.size() < n && k < 3000) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if (rx_data !== 8'h00) begin
      bad++; $display("FAIL reset_data: got %h, required 00", rx_data);
    end
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b, required 0", rx_valid);
    end
    total++;
    if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got ferr=%b ovr=%b, required 0/0", rx_frame_err, rx_overrun);
    end
    rst_n = 1'b1;
    repeat (10) tick();
    total++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      bad++; $display("FAIL post_reset_idle: got valid=%b data=%h, required 0/00", rx_valid, rx_data);
    end
  endtask

  task automatic test_single();
    int v0 = n_vrise;
    int f0 = n_ferr;
    int o0 = n_ovr;
    logic [7:0] e;
    rx_ready = 1'b1;
    exp_q.push_back(8'h6D);
    send_frame(8'h6D, 1'b1);
    repeat (20) tick();
    wait_got(1);
    e = exp_q.pop_front();
    total++;
    if (got_q.size() == 0) begin
      bad++; $display("FAIL single_data: no byte received, required %h", e);
    end else if (got_q[0] !== e) begin
      bad++; $display("FAIL single_data: got %h, required %h", got_q[0], e);
    end
    if (got_q.size() != 0) void'(got_q.pop_front());
    total++;
    if (n_vrise - v0 != 1) begin
      bad++; $display("FAIL single_valid_pulses: got %0d, required 1", n_vrise - v0);
    end
    total++;
    if (n_ferr != f0 || n_ovr != o0) begin
      bad++; $display("FAIL single_flags: got ferr=%0d ovr=%0d, required 0/0", n_ferr - f0, n_ovr - o0);
    end
  endtask

  task automatic test_back_to_back();
    int o0 = n_ovr;
    logic [7:0] e;
    rx_ready = 1'b0;
    exp_q.push_back(8'h6D);
    send_frame(8'h6D, 1'b1);
    send_frame(8'hD5, 1'b1);
    repeat (20) tick();
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h6D) begin
      bad++; $display("FAIL b2b_hold: got valid=%b data=%h, required 1/6d", rx_valid, rx_data);
    end
    total++;
    if (n_ovr - o0 != 1) begin
      bad++; $display("FAIL b2b_overrun: got %0d pulses, required 1", n_ovr - o0);
    end
    total++;
    if (n_long != 0 || n_both != 0) begin
      bad++; $display("FAIL b2b_pulse_shape: got long=%0d both=%0d, required 0/0", n_long, n_both);
    end
    rx_ready = 1'b1;
    wait_got(1);
    e = exp_q.pop_front();
    total++;
    if (got_q.size() == 0) begin
      bad++; $display("FAIL b2b_data: no byte received, required %h", e);
    end else if (got_q[0] !== e) begin
      bad++; $display("FAIL b2b_data: got %h, required %h", got_q[0], e);
    end
    if (got_q.size() != 0) void'(got_q.pop_front());
    repeat (2) tick();
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_valid_drop: got %b, required 0", rx_valid);
    end
  endtask

  task automatic test_frame_err();
    int v0 = n_vrise;
    int f0 = n_ferr;
    logic [7:0] e;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b0);
    repeat (20) tick();
    total++;
    if (n_ferr - f0 != 1) begin
      bad++; $display("FAIL ferr_pulse: got %0d pulses, required 1", n_ferr - f0);
    end
    total++;
    if (n_vrise != v0 || n_long != 0) begin
      bad++; $display("FAIL ferr_no_valid: got vrise=%0d long=%0d, required 0/0", n_vrise - v0, n_long);
    end
    repeat (CPB) tick();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (20) tick();
    wait_got(1);
    e = exp_q.pop_front();
    total++;
    if (got_q.size() == 0) begin
      bad++; $display("FAIL ferr_next_data: no byte received, required %h", e);
    end else if (got_q[0] !== e) begin
      bad++; $display("FAIL ferr_next_data: got %h, required %h", got_q[0], e);
    end
    if (got_q.size() != 0) void'(got_q.pop_front());
  endtask

  task automatic test_glitch();
    int v0 = n_vrise;
    int f0 = n_ferr;
    int o0 = n_ovr;
    rxd = 1'b0;
    repeat (100) tick();
    rxd = 1'b1;
    repeat (2 * CPB) tick();
    total++;
    if (n_vrise != v0 || n_ferr != f0 || n_ovr != o0) begin
      bad++; $display("FAIL glitch_events: got vrise=%0d ferr=%0d ovr=%0d, required 0/0/0",
                      n_vrise - v0, n_ferr - f0, n_ovr - o0);
    end
    total++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h3C) begin
      bad++; $display("FAIL glitch_outputs: got valid=%b data=%h, required 0/3c", rx_valid, rx_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pat = 8'hB6;
    logic [7:0] e;
    int f0;
    rx_ready = 1'b1;
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rxd = pat[i];
      repeat (CPB) tick();
    end
    rxd = pat[4];
    repeat (CPB / 2) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs: got data=%h valid=%b, required 00/0", rx_data, rx_valid);
    end
    total++;
    if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
      bad++; $display("FAIL midreset_flags: got ferr=%b ovr=%b, required 0/0", rx_frame_err, rx_overrun);
    end
    rxd = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    f0 = n_ferr;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    repeat (20) tick();
    wait_got(1);
    e = exp_q.pop_front();
    total++;
    if (got_q.size() == 0) begin
      bad++; $display("FAIL midreset_next_data: no byte received, required %h", e);
    end else if (got_q[0] !== e) begin
      bad++; $display("FAIL midreset_next_data: got %h, required %h", got_q[0], e);
    end
    if (got_q.size() != 0) void'(got_q.pop_front());
    total++;
    if (n_ferr != f0) begin
      bad++; $display("FAIL midreset_no_ferr: got %0d pulses, required 0", n_ferr - f0);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0 = n_vrise;
    int p0 = n_perr;
    logic [7:0] e;
    rx_ready = 1'b1;
    par_flip = 1'b1;
    send_frame(8'h6D, 1'b1);
    repeat (20) tick();
    total++;
    if (n_perr - p0 != 1 || n_vrise != v0) begin
      bad++; $display("FAIL parity_bad: got perr=%0d vrise=%0d, required 1/0", n_perr - p0, n_vrise - v0);
    end
    par_flip = 1'b0;
    repeat (CPB) tick();
    exp_q.push_back(8'h6D);
    send_frame(8'h6D, 1'b1);
    repeat (20) tick();
    wait_got(1);
    e = exp_q.pop_front();
    total++;
    if (got_q.size() == 0) begin
      bad++; $display("FAIL parity_good_data: no byte received, required %h", e);
    end else if (got_q[0] !== e) begin
      bad++; $display("FAIL parity_good_data: got %h, required %h", got_q[0], e);
    end
    if (got_q.size() != 0) void'(got_q.pop_front());
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    repeat (CPB) tick();
    test_back_to_back();
    repeat (CPB) tick();
    test_frame_err();
    repeat (CPB) tick();
    test_glitch();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    repeat (CPB) tick();
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
